// File: rtl/ca90_item_fetch_if.sv
// Request/result bundle for the CA90 item fetcher.
// slave = fetcher side, master = requester/consumer side.
interface ca90_item_fetch_if #(
   parameter int Dimension = 512,
   parameter int AddrWidth = 8
);
   logic [Dimension-1:0] seed_i;
   logic                 flush_i;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [AddrWidth-1:0] addr_i;
   logic                 vec_valid_o;
   logic                 vec_ready_i;
   logic [Dimension-1:0] vector_o;

   modport slave (
      input  seed_i, flush_i, req_valid_i, addr_i, vec_ready_i,
      output req_ready_o, vec_valid_o, vector_o
   );

   modport master (
      output seed_i, flush_i, req_valid_i, addr_i, vec_ready_i,
      input  req_ready_o, vec_valid_o, vector_o
   );
endinterface

// File: rtl/ca90_item_fetch.sv
// Regenerates item vector N from seed_i by N CA90 steps (one per cycle); valid N+1 cycles after accept.
// One request in flight; result held until vec_ready_i. Optional last-result cache: CA90_CACHE_EN.
module ca90_item_fetch #(
   parameter int Dimension = 512,
   parameter int ShiftAmt  = 1,
   parameter int AddrWidth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   ca90_item_fetch_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   function automatic logic [Dimension-1:0] ca90(input logic [Dimension-1:0] v);
      logic [Dimension-1:0] rl;
      logic [Dimension-1:0] rr;
      rl = (v << ShiftAmt) | (v >> (Dimension - ShiftAmt));
      rr = (v >> ShiftAmt) | (v << (Dimension - ShiftAmt));
      return rl ^ rr;
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic [Dimension-1:0] r_work;
   logic [Dimension-1:0] w_work_nxt;
   logic [AddrWidth-1:0] r_cnt;
   logic [AddrWidth-1:0] w_cnt_nxt;
   logic [AddrWidth-1:0] w_start_cnt;
   logic [AddrWidth-1:0] w_hit_diff;
   logic                 w_accept;
   logic                 w_release;
   logic                 w_hit;

   assign w_accept  = bus.req_valid_i & (r_state == S_IDLE);
   assign w_release = bus.vec_ready_i & (r_state == S_HOLD);

`ifdef CA90_CACHE_EN
   logic [AddrWidth-1:0] r_req_addr;
   logic [AddrWidth-1:0] r_last_addr;
   logic                 r_cache_vld;

   // A flush in the accept cycle forces a miss for that very request.
   assign w_hit      = r_cache_vld & ~bus.flush_i & (bus.addr_i >= r_last_addr);
   assign w_hit_diff = bus.addr_i - r_last_addr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_req_addr  <= '0;
         r_last_addr <= '0;
         r_cache_vld <= 1'b0;
      end else begin
         if (w_accept) begin
            r_req_addr <= bus.addr_i;
         end
         if (w_release) begin
            r_last_addr <= r_req_addr;
            r_cache_vld <= 1'b1;
         end else if (bus.flush_i && r_state == S_IDLE) begin
            r_cache_vld <= 1'b0;
         end
      end
   end
`else
   logic w_unused_flush;

   assign w_hit          = 1'b0;
   assign w_hit_diff     = '0;
   assign w_unused_flush = bus.flush_i;
`endif

   assign w_start_cnt = w_hit ? w_hit_diff : bus.addr_i;

   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               // On a hit the working register already holds item last_addr.
               if (!w_hit) begin
                  w_work_nxt = bus.seed_i;
               end
               w_cnt_nxt   = w_start_cnt;
               w_state_nxt = (w_start_cnt == '0) ? S_HOLD : S_GEN;
            end
         end
         S_GEN: begin
            w_work_nxt = ca90(r_work);
            w_cnt_nxt  = r_cnt - 1'b1;
            if (r_cnt == AddrWidth'(1)) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_release) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign bus.req_ready_o = (r_state == S_IDLE);
   assign bus.vec_valid_o = (r_state == S_HOLD);
   assign bus.vector_o    = r_work;

endmodule

// File: tb/tb_ca90_item_fetch.sv
// Bench for ca90_item_fetch (Dimension=8, ShiftAmt=1, AddrWidth=4); vector table plus scoreboard queue.
// Build with CA90_CACHE_EN defined to select the cached-latency column.
module tb_ca90_item_fetch;
   localparam int DIM = 8;
   localparam int AW  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ca90_item_fetch_if #(.Dimension(DIM), .AddrWidth(AW)) bus ();

   ca90_item_fetch #(.Dimension(DIM), .ShiftAmt(1), .AddrWidth(AW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] seed;
      logic [3:0] addr;
      logic       flush;
      int         hold;
      logic [7:0] vec;
      int         lat_nc;
      int         lat_c;
   } vec_t;

   typedef struct {
      logic [7:0] vec;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[10];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic wait_ready(input string name);
      int t = 0;
      while (bus.req_ready_o !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) timeout(name);
   endtask

   task automatic run_entry(input vec_t e, input int idx);
      exp_t ex;
      exp_t got;
      int   lat;
      logic ready_seen;
      string tag;
      tag = $sformatf("entry%0d", idx);
      @(negedge clk);
      bus.seed_i  = e.seed;
      bus.flush_i = e.flush;
      wait_ready({tag, "_ready"});
      bus.req_valid_i = 1'b1;
      bus.addr_i      = e.addr;
      ex.vec = e.vec;
`ifdef CA90_CACHE_EN
      ex.lat = e.lat_c;
`else
      ex.lat = e.lat_nc;
`endif
      @(posedge clk);
      sb_q.push_back(ex);
      @(negedge clk);
      // Scramble inputs: the in-flight request must not depend on them.
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      bus.addr_i      = 4'($urandom);
      bus.seed_i      = 8'($urandom);
      lat        = 1;
      ready_seen = 1'b0;
      while (bus.vec_valid_o !== 1'b1 && lat < 40) begin
         if (bus.req_ready_o !== 1'b0) ready_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) begin
         timeout({tag, "_valid"});
         return;
      end
      got = sb_q.pop_front();
      check({tag, "_vector"}, bus.vector_o, got.vec);
      check({tag, "_latency"}, lat, got.lat);
      if (got.lat > 1) check({tag, "_gen_ready_low"}, ready_seen, 1'b0);
      for (int k = 0; k < e.hold; k++) begin
         bus.req_valid_i = 1'b1;
         @(negedge clk);
         check({tag, "_hold_valid"}, bus.vec_valid_o, 1'b1);
         check({tag, "_hold_vector"}, bus.vector_o, got.vec);
      end
      bus.req_valid_i = 1'b0;
      check({tag, "_hold_ready_low"}, bus.req_ready_o, 1'b0);
      bus.vec_ready_i = 1'b1;
      @(negedge clk);
      bus.vec_ready_i = 1'b0;
      check({tag, "_release"}, {bus.vec_valid_o, bus.req_ready_o}, 2'b01);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      bus.seed_i = 8'h01;
      wait_ready("midrst_ready");
      bus.req_valid_i = 1'b1;
      bus.addr_i      = 4'd15;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("midrst_gen_ready_low", bus.req_ready_o, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("midrst_gen_valid_low", bus.vec_valid_o, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", bus.req_ready_o, 1'b1);
      check("midrst_valid", bus.vec_valid_o, 1'b0);
      check("midrst_vector", bus.vector_o, 8'h00);
   endtask

   initial begin
      rst             = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.vec_ready_i = 1'b0;
      bus.flush_i     = 1'b0;
      bus.addr_i      = '0;
      bus.seed_i      = 8'h01;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready", bus.req_ready_o, 1'b1);
      check("reset_valid", bus.vec_valid_o, 1'b0);
      check("reset_vector", bus.vector_o, 8'h00);
      rst = 1'b0;

      // seed, addr, flush, hold, vector, latency uncached, latency cached
      tbl[0] = '{8'h01, 4'd0,  1'b0, 0, 8'h01, 1,  1};
      tbl[1] = '{8'h01, 4'd3,  1'b0, 0, 8'hAA, 4,  4};
      tbl[2] = '{8'h01, 4'd4,  1'b0, 5, 8'h00, 5,  2};
      tbl[3] = '{8'h01, 4'd2,  1'b0, 0, 8'h44, 3,  3};
      tbl[4] = '{8'h01, 4'd3,  1'b0, 0, 8'hAA, 4,  2};
      tbl[5] = '{8'h01, 4'd1,  1'b0, 0, 8'h82, 2,  2};
      tbl[6] = '{8'h01, 4'd1,  1'b1, 0, 8'h82, 2,  2};
      tbl[7] = '{8'h01, 4'd15, 1'b0, 0, 8'h00, 16, 15};
      tbl[8] = '{8'h03, 4'd2,  1'b1, 0, 8'hCC, 3,  3};
      tbl[9] = '{8'h03, 4'd2,  1'b0, 2, 8'hCC, 3,  1};

      for (int i = 0; i < 10; i++) begin
         if (i == 3) mid_reset();
         run_entry(tbl[i], i);
      end
      check("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
